// File: rtl/glu_wait_ctrl_pkg.sv
// Shared definitions for the gluclock Z80 wait bridge: FSM encoding,
// timeout defaults and the idle value of the read bus.
package glu_wait_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ~36 ms at 28 MHz; the counter width must satisfy 2^TMO_W > TMO_CYCLES.
  localparam int unsigned TMO_CYCLES_DEF = 1000000;
  localparam int unsigned TMO_W_DEF      = 20;

  localparam logic [7:0] DOUT_IDLE = 8'hFF;

endpackage

// File: rtl/glu_tmo_cnt.sv
// WAIT timeout counter: counts while enabled and flags the cycle in which the
// count sits at TMO_CYCLES-1, so the release lands TMO_CYCLES cycles after entry.
module glu_tmo_cnt
  import glu_wait_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int unsigned TMO_W      = TMO_W_DEF
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/glu_wait_ctrl.sv
// Z80-side bridge for the AVR-served gluclock ports: latches address/data,
// holds the Z80 in WAIT until the SPI slave answers or the timeout fires.
module glu_wait_ctrl
  import glu_wait_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int unsigned TMO_W      = TMO_W_DEF
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       addr_wr_stb,
  input  logic       data_wr_stb,
  input  logic       data_rd_stb,
  input  logic       io_end,
  input  logic [7:0] din,
  input  logic [7:0] wait_read,
  input  logic       wait_end,
  output logic [7:0] gluclock_addr,
  output logic [7:0] wait_write,
  output logic       wait_rnw,
  output logic       wait_n,
  output logic [7:0] dout,
  output logic       wait_pending,
  output logic       tmo_flag
);

  state_t state;
  logic   expire;
  logic   cnt_en;
  logic   cnt_clr;

  assign cnt_en  = (state == ST_WAIT);
  assign cnt_clr = (state == ST_DONE) && io_end;

  glu_tmo_cnt #(
    .TMO_CYCLES (TMO_CYCLES),
    .TMO_W      (TMO_W)
  ) u_tmo_cnt (
    .fclk   (fclk),
    .rst_n  (rst_n),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .expire (expire)
  );

  // NOTE: every output is a flop with an asynchronous reset value, so pulling
  // rst_n low releases the Z80 WAIT line without waiting for a clock edge.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      gluclock_addr <= 8'h00;
      wait_write    <= 8'h00;
      wait_rnw      <= 1'b1;
      wait_n        <= 1'b1;
      dout          <= DOUT_IDLE;
      wait_pending  <= 1'b0;
      tmo_flag      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_wr_stb) begin
            wait_write   <= din;
            wait_rnw     <= 1'b0;
            tmo_flag     <= 1'b0;
            wait_n       <= 1'b0;
            wait_pending <= 1'b1;
            state        <= ST_WAIT;
          end else if (data_rd_stb) begin
            wait_rnw     <= 1'b1;
            tmo_flag     <= 1'b0;
            wait_n       <= 1'b0;
            wait_pending <= 1'b1;
            state        <= ST_WAIT;
          end else if (addr_wr_stb) begin
            gluclock_addr <= din;
          end
        end
        ST_WAIT: begin
          // An AVR answer in the expiry cycle still counts as a normal reply.
          if (wait_end) begin
            dout         <= wait_rnw ? wait_read : DOUT_IDLE;
            wait_n       <= 1'b1;
            wait_pending <= 1'b0;
            state        <= ST_DONE;
          end else if (expire) begin
            dout         <= DOUT_IDLE;
            tmo_flag     <= 1'b1;
            wait_n       <= 1'b1;
            wait_pending <= 1'b0;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (io_end) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glu_wait_ctrl.sv
// Self-checking bench for glu_wait_ctrl: directed scenarios plus random traffic,
// compared every cycle against a request-level model of the bridge.
module tb_glu_wait_ctrl;

  localparam int T = 24;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       addr_wr_stb = 1'b0;
  logic       data_wr_stb = 1'b0;
  logic       data_rd_stb = 1'b0;
  logic       io_end = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] wait_read = 8'h00;
  logic       wait_end = 1'b0;
  logic [7:0] gluclock_addr;
  logic [7:0] wait_write;
  logic       wait_rnw;
  logic       wait_n;
  logic [7:0] dout;
  logic       wait_pending;
  logic       tmo_flag;

  int n_cmp = 0;
  int n_bad = 0;

  glu_wait_ctrl #(
    .TMO_CYCLES (T),
    .TMO_W      (5)
  ) dut (
    .fclk          (fclk),
    .rst_n         (rst_n),
    .addr_wr_stb   (addr_wr_stb),
    .data_wr_stb   (data_wr_stb),
    .data_rd_stb   (data_rd_stb),
    .io_end        (io_end),
    .din           (din),
    .wait_read     (wait_read),
    .wait_end      (wait_end),
    .gluclock_addr (gluclock_addr),
    .wait_write    (wait_write),
    .wait_rnw      (wait_rnw),
    .wait_n        (wait_n),
    .dout          (dout),
    .wait_pending  (wait_pending),
    .tmo_flag      (tmo_flag)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request-level model: a request is either outstanding (m_busy, with the
  // number of cycles already spent waiting) or answered and awaiting io_end.
  bit         m_busy, m_done;
  int         m_waited;
  logic [7:0] m_addr, m_wdata, m_dout;
  logic       m_rnw, m_tmo;

  always @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_waited <= 0;
      m_addr <= 8'h00; m_wdata <= 8'h00; m_dout <= 8'hFF;
      m_rnw <= 1'b1; m_tmo <= 1'b0;
    end else if (m_busy) begin
      m_waited <= m_waited + 1;
      if (wait_end) begin
        m_dout <= m_rnw ? wait_read : 8'hFF;
        m_busy <= 0; m_done <= 1;
      end else if (m_waited + 1 == T) begin
        m_dout <= 8'hFF; m_tmo <= 1'b1;
        m_busy <= 0; m_done <= 1;
      end
    end else if (m_done) begin
      if (io_end) m_done <= 0;
    end else begin
      if (data_wr_stb) begin
        m_wdata <= din; m_rnw <= 1'b0; m_tmo <= 1'b0; m_busy <= 1; m_waited <= 0;
      end else if (data_rd_stb) begin
        m_rnw <= 1'b1; m_tmo <= 1'b0; m_busy <= 1; m_waited <= 0;
      end else if (addr_wr_stb) begin
        m_addr <= din;
      end
    end
  end

  always @(negedge fclk) begin
    check("cycle", {4'h0, gluclock_addr, wait_write, wait_rnw, wait_n, dout, wait_pending, tmo_flag},
                   {4'h0, m_addr, m_wdata, m_rnw, !m_busy, m_dout, m_busy, m_tmo});
  end

  // Applies one cycle of inputs, then returns at the following negedge with inputs cleared.
  task automatic pulse(input logic wr, input logic rd, input logic aw, input logic we,
                       input logic ioe, input logic [7:0] d, input logic [7:0] rdat);
    @(negedge fclk);
    data_wr_stb = wr; data_rd_stb = rd; addr_wr_stb = aw;
    wait_end = we; io_end = ioe; din = d; wait_read = rdat;
    @(negedge fclk);
    data_wr_stb = 0; data_rd_stb = 0; addr_wr_stb = 0; wait_end = 0; io_end = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int low;

    repeat (3) @(negedge fclk);
    check("rst_wait_n", wait_n, 1);
    check("rst_pending", wait_pending, 0);
    check("rst_dout", dout, 8'hFF);
    check("rst_rnw", wait_rnw, 1);
    check("rst_addr", gluclock_addr, 8'h00);
    rst_n = 1;

    // Read with AVR reply 20 cycles after entry.
    pulse(0, 0, 1, 0, 0, 8'h0C, 8'h00);
    check("addr_latch", gluclock_addr, 8'h0C);
    check("addr_no_stall", wait_n, 1);
    pulse(0, 1, 0, 0, 0, 8'h00, 8'h00);
    low = wait_n ? 0 : 1;
    repeat (19) begin
      @(negedge fclk);
      if (!wait_n) low++;
    end
    wait_end = 1; wait_read = 8'h5A;
    @(negedge fclk);
    wait_end = 0;
    check("rd_low_cycles", low, 20);
    check("rd_dout", dout, 8'h5A);
    check("rd_rnw", wait_rnw, 1);
    check("rd_tmo", tmo_flag, 0);
    check("rd_released", wait_n, 1);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);

    // Spurious wait_end in IDLE.
    pulse(0, 0, 0, 1, 0, 8'h00, 8'h33);
    check("idle_wait_end_dout", dout, 8'h5A);

    // Write, then a read strobe while DONE must be ignored.
    pulse(1, 0, 0, 0, 0, 8'hA3, 8'h00);
    check("wr_data", wait_write, 8'hA3);
    check("wr_rnw", wait_rnw, 0);
    check("wr_pending", wait_pending, 1);
    pulse(0, 0, 0, 1, 0, 8'h00, 8'h11);
    check("wr_dout", dout, 8'hFF);
    check("wr_pending_off", wait_pending, 0);
    pulse(0, 1, 0, 0, 0, 8'h00, 8'h00);
    check("done_rd_ignored", wait_n, 1);
    check("done_rd_rnw", wait_rnw, 0);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    pulse(0, 1, 0, 0, 0, 8'h00, 8'h00);
    check("rd_after_io_end", wait_n, 0);
    pulse(0, 0, 0, 1, 0, 8'h00, 8'h99);
    check("rd2_dout", dout, 8'h99);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);

    // Timeout.
    pulse(0, 1, 0, 0, 0, 8'h00, 8'h00);
    low = wait_n ? 0 : 1;
    for (int k = 0; k < 100 && !wait_n; k++) begin
      @(negedge fclk);
      if (!wait_n) low++;
    end
    check("tmo_low_cycles", low, T);
    check("tmo_flag_set", tmo_flag, 1);
    check("tmo_dout", dout, 8'hFF);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);
    pulse(1, 0, 0, 0, 0, 8'h3C, 8'h00);
    check("tmo_cleared_by_wr", tmo_flag, 0);
    pulse(0, 0, 0, 1, 0, 8'h00, 8'h00);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);

    // wait_end in the expiry cycle wins over the timeout.
    pulse(0, 1, 0, 0, 0, 8'h00, 8'h00);
    repeat (T - 1) @(negedge fclk);
    wait_end = 1; wait_read = 8'hC6;
    @(negedge fclk);
    wait_end = 0;
    check("edge_tmo_flag", tmo_flag, 0);
    check("edge_dout", dout, 8'hC6);
    check("edge_released", wait_n, 1);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);

    // Priority, addr write during WAIT, wait_end during DONE.
    pulse(1, 1, 0, 0, 0, 8'h77, 8'h00);
    check("prio_rnw", wait_rnw, 0);
    check("prio_wdata", wait_write, 8'h77);
    pulse(0, 0, 1, 0, 0, 8'hEE, 8'h00);
    check("wait_addr_kept", gluclock_addr, 8'h0C);
    pulse(0, 0, 0, 1, 0, 8'h00, 8'h12);
    check("prio_dout", dout, 8'hFF);
    pulse(0, 0, 0, 1, 0, 8'h00, 8'h34);
    check("done_wait_end_dout", dout, 8'hFF);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);

    // Asynchronous reset in the middle of WAIT.
    pulse(0, 1, 0, 0, 0, 8'h00, 8'h00);
    @(posedge fclk);
    #2 rst_n = 0;
    #1;
    check("arst_wait_n", wait_n, 1);
    check("arst_pending", wait_pending, 0);
    check("arst_dout", dout, 8'hFF);
    check("arst_addr", gluclock_addr, 8'h00);
    @(negedge fclk);
    rst_n = 1;
    pulse(0, 0, 1, 0, 0, 8'h05, 8'h00);
    pulse(0, 1, 0, 0, 0, 8'h00, 8'h00);
    check("post_rst_wait", wait_n, 0);
    pulse(0, 0, 0, 1, 0, 8'h00, 8'hAB);
    check("post_rst_dout", dout, 8'hAB);
    check("post_rst_addr", gluclock_addr, 8'h05);
    pulse(0, 0, 0, 0, 1, 8'h00, 8'h00);

    // Random traffic checked by the per-cycle compare.
    for (int i = 0; i < 3000; i++) begin
      @(negedge fclk);
      data_wr_stb = ($urandom_range(7) == 0);
      data_rd_stb = ($urandom_range(7) == 0);
      addr_wr_stb = ($urandom_range(7) == 0);
      wait_end    = ($urandom_range(15) == 0);
      io_end      = ($urandom_range(3) == 0);
      din         = 8'($urandom);
      wait_read   = 8'($urandom);
    end
    @(negedge fclk);
    data_wr_stb = 0; data_rd_stb = 0; addr_wr_stb = 0; wait_end = 0; io_end = 0;
    repeat (2) @(negedge fclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
